// File: rtl/sprite_pkg.sv
// Shared constants and types for the Watergirl sprite fetch stage.
package sprite_pkg;

  localparam int unsigned SpriteW    = 32;
  localparam int unsigned SpriteH    = 32;
  localparam int unsigned Frames     = 4;
  localparam int unsigned FrameTicks = 8;
  localparam int unsigned RomLat     = 1;
  localparam logic [3:0]  TranspIdx  = 4'd0;

  typedef logic [3:0] pix_idx_t;

  typedef enum logic {
    StIdle,
    StWalk
  } anim_state_t;

endpackage

// File: rtl/sprite_anim_fsm.sv
// Walk-animation sequencer: steps the frame every FRAME_TICKS frame_start pulses while moving.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES      = Frames,
  parameter int unsigned FRAME_TICKS = FrameTicks,
  localparam int unsigned FrameW     = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned TickW      = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_start_i,
  input  logic              moving_i,
  output logic [FrameW-1:0] anim_frame_o
);

  anim_state_t       state_q;
  logic [TickW-1:0]  tick_q;
  logic [FrameW-1:0] frame_q;

  // moving_i is only looked at on frame_start, so it acts as its own shadow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tick_q  <= '0;
      frame_q <= '0;
    end else if (frame_start_i) begin
      case (state_q)
        StIdle: begin
          tick_q  <= '0;
          frame_q <= '0;
          if (moving_i) state_q <= StWalk;
        end
        StWalk: begin
          if (!moving_i) begin
            state_q <= StIdle;
            tick_q  <= '0;
            frame_q <= '0;
          end else if (tick_q == TickW'(FRAME_TICKS - 1)) begin
            tick_q  <= '0;
            frame_q <= (frame_q == FrameW'(FRAMES - 1)) ? '0 : frame_q + FrameW'(1);
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign anim_frame_o = frame_q;

endmodule

// File: rtl/girl_sprite_fetch.sv
// Sprite fetch: shadowed position, box hit test, ROM address generation and
// hit/index alignment to the ROM read latency.
module girl_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W    = SpriteW,
  parameter int unsigned SPRITE_H    = SpriteH,
  parameter int unsigned FRAMES      = Frames,
  parameter int unsigned FRAME_TICKS = FrameTicks,
  parameter int unsigned ROM_LAT     = RomLat,
  parameter logic [3:0]  TRANSP_IDX  = TranspIdx,
  parameter int unsigned ADDR_W      = $clog2(FRAMES * SPRITE_W * SPRITE_H),
  localparam int unsigned FrameW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_start_i,
  input  logic              blank_n_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        sprite_x_i,
  input  logic [9:0]        sprite_y_i,
  input  logic              moving_i,
  input  logic              face_left_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  pix_idx_t          rom_index_i,
  output pix_idx_t          pix_index_o,
  output logic              pix_hit_o,
  output logic [FrameW-1:0] anim_frame_o
);

  localparam int unsigned ColW = $clog2(SPRITE_W);
  localparam int unsigned RowW = $clog2(SPRITE_H);

  logic [9:0]        sx_q, sy_q;
  logic              face_q;
  logic              hit;
  logic [ColW-1:0]   col, mcol;
  logic [RowW-1:0]   row;
  logic [ADDR_W-1:0] addr_d;
  logic [ROM_LAT:0]  hit_pipe_q;
  logic              hit_d;
  pix_idx_t          pix_index_q;
  logic              pix_hit_q;

  sprite_anim_fsm #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_anim (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_start_i (frame_start_i),
    .moving_i      (moving_i),
    .anim_frame_o  (anim_frame_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q   <= '0;
      sy_q   <= '0;
      face_q <= 1'b0;
    end else if (frame_start_i) begin
      sx_q   <= sprite_x_i;
      sy_q   <= sprite_y_i;
      face_q <= face_left_i;
    end
  end

  // 11-bit compares so a box hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    hit = blank_n_i
        && ({1'b0, draw_x_i} >= {1'b0, sx_q})
        && ({1'b0, draw_x_i} <  ({1'b0, sx_q} + 11'(SPRITE_W)))
        && ({1'b0, draw_y_i} >= {1'b0, sy_q})
        && ({1'b0, draw_y_i} <  ({1'b0, sy_q} + 11'(SPRITE_H)));
    col    = draw_x_i[ColW-1:0] - sx_q[ColW-1:0];
    row    = draw_y_i[RowW-1:0] - sy_q[RowW-1:0];
    mcol   = face_q ? (ColW'(SPRITE_W - 1) - col) : col;
    addr_d = hit ? ADDR_W'({anim_frame_o, row, mcol}) : '0;
  end

  assign hit_d = hit_pipe_q[ROM_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rom_addr_o  <= '0;
      hit_pipe_q  <= '0;
      pix_index_q <= '0;
      pix_hit_q   <= 1'b0;
    end else begin
      rom_addr_o  <= addr_d;
      hit_pipe_q  <= (ROM_LAT + 1)'({hit_pipe_q, hit});
      pix_index_q <= hit_d ? rom_index_i : '0;
      pix_hit_q   <= hit_d && (rom_index_i != TRANSP_IDX);
    end
  end

  assign pix_index_o = pix_index_q;
  assign pix_hit_o   = pix_hit_q;

endmodule
